// File: rtl/alu_op_sequencer.sv
// ALU issue sequencer: decodes MIPS fields into a 3-bit ALU op,
// drives registered operands and captures result/flags.
module alu_op_sequencer #(
  parameter int          DW      = 32,
  parameter logic [DW-1:0] ERR_VAL = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_opcode,
  input  logic [5:0]    in_funct,
  input  logic [15:0]   in_imm,
  input  logic [DW-1:0] in_rs_val,
  input  logic [DW-1:0] in_rt_val,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_o,
  input  logic          alu_zf,
  input  logic          alu_of,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_res,
  output logic          out_zf,
  output logic          out_of,
  output logic          out_err,
  output logic          out_div0
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [2:0]    dec_op;
  logic [DW-1:0] dec_b;
  logic          dec_err;
  logic          accept;
  logic          err_q;
  logic          div0_q;

  logic [DW-1:0] imm_sx;
  logic [DW-1:0] imm_zx;

  assign imm_sx = {{(DW-16){in_imm[15]}}, in_imm};
  assign imm_zx = {{(DW-16){1'b0}}, in_imm};

  // Instruction field decode into ALU op and b operand
  always_comb begin
    dec_op  = OP_ADD;
    dec_b   = in_rt_val;
    dec_err = 1'b0;
    case (in_opcode)
      6'h00: begin
        case (in_funct)
          6'h20, 6'h21: dec_op = OP_ADD;
          6'h22, 6'h23: dec_op = OP_SUB;
          6'h18:        dec_op = OP_MUL;
          6'h1A:        dec_op = OP_DIV;
          6'h24:        dec_op = OP_AND;
          6'h25:        dec_op = OP_OR;
          6'h26:        dec_op = OP_XOR;
          6'h27:        dec_op = OP_NOR;
          default:      dec_err = 1'b1;
        endcase
      end
      6'h08, 6'h23, 6'h2B: begin
        dec_op = OP_ADD;
        dec_b  = imm_sx;
      end
      6'h0C: begin
        dec_op = OP_AND;
        dec_b  = imm_zx;
      end
      6'h0D: begin
        dec_op = OP_OR;
        dec_b  = imm_zx;
      end
      6'h0E: begin
        dec_op = OP_XOR;
        dec_b  = imm_zx;
      end
      6'h04, 6'h05: dec_op = OP_SUB;
      default: dec_err = 1'b1;
    endcase
  end

  // Next-state, handshake and acceptance logic
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept   = 1'b1;
            state_nx = EXEC;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand latch on accept, result capture at end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      err_q    <= 1'b0;
      div0_q   <= 1'b0;
      out_res  <= '0;
      out_zf   <= 1'b0;
      out_of   <= 1'b0;
      out_err  <= 1'b0;
      out_div0 <= 1'b0;
    end else begin
      if (accept) begin
        alu_a  <= in_rs_val;
        alu_b  <= dec_b;
        alu_op <= dec_op;
        err_q  <= dec_err;
        div0_q <= (dec_op == OP_DIV) && (dec_b == '0);
      end
      if (state == EXEC) begin
        out_err  <= err_q;
        out_div0 <= div0_q;
        if (err_q || div0_q) begin
          out_res <= ERR_VAL;
          out_zf  <= 1'b0;
          out_of  <= 1'b0;
        end else begin
          out_res <= alu_o;
          out_zf  <= alu_zf;
          out_of  <= alu_of;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU
// attached to the alu_* port.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_o;
  logic        alu_zf;
  logic        alu_of;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_zf;
  logic        out_of;
  logic        out_err;
  logic        out_div0;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct),
    .in_imm(in_imm), .in_rs_val(in_rs_val),
    .in_rt_val(in_rt_val),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_o(alu_o), .alu_zf(alu_zf), .alu_of(alu_of),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_zf(out_zf),
    .out_of(out_of), .out_err(out_err),
    .out_div0(out_div0)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU
  always_comb begin
    alu_o  = '0;
    alu_of = 1'b0;
    case (alu_op)
      3'd0: begin
        alu_o  = alu_a + alu_b;
        alu_of = (alu_a[31] == alu_b[31]) && (alu_o[31] != alu_a[31]);
      end
      3'd1: begin
        alu_o  = alu_a - alu_b;
        alu_of = (alu_a[31] != alu_b[31]) && (alu_o[31] != alu_a[31]);
      end
      3'd2: alu_o = alu_a * alu_b;
      3'd3: alu_o = (alu_b == 0) ? 32'd0 : alu_a / alu_b;
      3'd4: alu_o = alu_a & alu_b;
      3'd5: alu_o = alu_a | alu_b;
      3'd6: alu_o = alu_a ^ alu_b;
      default: alu_o = ~(alu_a | alu_b);
    endcase
    alu_zf = (alu_o == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an instruction while IDLE; returns one negedge later (in EXEC)
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt);
    in_opcode = op;
    in_funct  = fn;
    in_imm    = imm;
    in_rs_val = rs;
    in_rt_val = rt;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_opcode = '0;
    in_funct = '0;
    in_imm = '0;
    in_rs_val = '0;
    in_rt_val = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_res", out_res, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: add 5+7
    issue(6'h00, 6'h20, 16'h0, 32'd5, 32'd7);
    chk("t1_exec_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_exec_ready", {31'd0, in_ready}, 32'd0);
    chk("t1_alu_op", {29'd0, alu_op}, 32'd0);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_b", alu_b, 32'd7);
    @(negedge clk);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_res", out_res, 32'd12);
    chk("t1_zf", {31'd0, out_zf}, 32'd0);
    release_out();
    chk("t1_idle_valid", {31'd0, out_valid}, 32'd0);

    // 2: sub 9-9, beq 3-3
    issue(6'h00, 6'h22, 16'h0, 32'd9, 32'd9);
    chk("t2_alu_op", {29'd0, alu_op}, 32'd1);
    @(negedge clk);
    chk("t2_res", out_res, 32'd0);
    chk("t2_zf", {31'd0, out_zf}, 32'd1);
    release_out();
    issue(6'h04, 6'h00, 16'h0010, 32'd3, 32'd3);
    chk("t2b_alu_op", {29'd0, alu_op}, 32'd1);
    chk("t2b_alu_b", alu_b, 32'd3);
    @(negedge clk);
    chk("t2b_res", out_res, 32'd0);
    chk("t2b_zf", {31'd0, out_zf}, 32'd1);
    release_out();

    // 3: addi sign-extend, ori zero-extend
    issue(6'h08, 6'h00, 16'hFFFF, 32'd1, 32'd0);
    chk("t3_alu_b", alu_b, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("t3_res", out_res, 32'd0);
    chk("t3_of", {31'd0, out_of}, 32'd0);
    release_out();
    issue(6'h0D, 6'h00, 16'hFFFF, 32'd0, 32'd0);
    chk("t3b_alu_op", {29'd0, alu_op}, 32'd5);
    chk("t3b_alu_b", alu_b, 32'h0000_FFFF);
    @(negedge clk);
    chk("t3b_res", out_res, 32'h0000_FFFF);
    release_out();

    // signed overflow on add
    issue(6'h00, 6'h20, 16'h0, 32'h7FFF_FFFF, 32'd1);
    @(negedge clk);
    chk("of_res", out_res, 32'h8000_0000);
    chk("of_flag", {31'd0, out_of}, 32'd1);
    release_out();

    // 4: div by zero, illegal opcode
    issue(6'h00, 6'h1A, 16'h0, 32'd10, 32'd0);
    chk("t4_alu_op", {29'd0, alu_op}, 32'd3);
    @(negedge clk);
    chk("t4_div0", {31'd0, out_div0}, 32'd1);
    chk("t4_err", {31'd0, out_err}, 32'd0);
    chk("t4_res", out_res, 32'hFFFF_FFFF);
    chk("t4_zf", {31'd0, out_zf}, 32'd0);
    release_out();
    issue(6'h3F, 6'h20, 16'h0, 32'd4, 32'd4);
    chk("t4b_alu_op", {29'd0, alu_op}, 32'd0);
    @(negedge clk);
    chk("t4b_err", {31'd0, out_err}, 32'd1);
    chk("t4b_div0", {31'd0, out_div0}, 32'd0);
    chk("t4b_res", out_res, 32'hFFFF_FFFF);
    release_out();

    // 5: backpressure in DONE, then back-to-back accept
    issue(6'h00, 6'h24, 16'h0, 32'h0000_F0F0, 32'h0000_FF00);
    @(negedge clk);
    in_opcode = 6'h00;
    in_funct  = 6'h26;
    in_rs_val = 32'd3;
    in_rt_val = 32'd5;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_hold_res", out_res, 32'h0000_F000);
      chk("t5_hold_op", {29'd0, alu_op}, 32'd4);
      chk("t5_hold_a", alu_a, 32'h0000_F0F0);
      chk("t5_hold_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("t5_rel_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t5_b2b_op", {29'd0, alu_op}, 32'd6);
    chk("t5_b2b_a", alu_a, 32'd3);
    chk("t5_b2b_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("t5_b2b_done", {31'd0, out_valid}, 32'd1);
    chk("t5_b2b_res", out_res, 32'd6);
    release_out();

    // 6: reset during EXEC
    issue(6'h00, 6'h20, 16'h0, 32'd1, 32'd2);
    chk("t6_exec_op_a", alu_a, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_res", out_res, 32'd0);
    chk("t6_alu_a", alu_a, 32'd0);
    chk("t6_alu_b", alu_b, 32'd0);
    @(negedge clk);
    chk("t6_stay_idle", {31'd0, out_valid}, 32'd0);

    // recovery after reset
    issue(6'h00, 6'h27, 16'h0, 32'd0, 32'd0);
    @(negedge clk);
    chk("rec_res", out_res, 32'hFFFF_FFFF);
    chk("rec_err", {31'd0, out_err}, 32'd0);
    release_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
